// File: rtl/logicnet_pkg.sv
// Shared constants and types for the LogicNet input quantizer front end.
package logicnet_pkg;

    localparam int QBITS   = 2;
    localparam int NUM_THR = 3;

    // Every feature powers up with the same three thresholds.
    localparam int THR_DEFAULT [NUM_THR] = '{-8192, 0, 8192};

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } asm_state_t;

endpackage

// File: rtl/logicnet_feature_quant.sv
// Combinational thermometer-count quantizer: counts how many of three
// signed thresholds the sample meets or exceeds.
module logicnet_feature_quant
    import logicnet_pkg::*;
#(
    parameter int IN_WIDTH = 16
) (
    input  logic [IN_WIDTH-1:0] x,
    input  logic [IN_WIDTH-1:0] t0,
    input  logic [IN_WIDTH-1:0] t1,
    input  logic [IN_WIDTH-1:0] t2,
    output logic [QBITS-1:0]    code
);

    logic ge0;
    logic ge1;
    logic ge2;

    // Thresholds need not be ordered, so each compare is counted independently.
    always_comb begin
        ge0  = $signed(x) >= $signed(t0);
        ge1  = $signed(x) >= $signed(t1);
        ge2  = $signed(x) >= $signed(t2);
        code = {1'b0, ge0} + {1'b0, ge1} + {1'b0, ge2};
    end

endmodule

// File: rtl/logicnet_input_quantizer.sv
// Quantizes a stream of signed feature samples and packs each frame of
// NUM_FEATURES 2-bit codes into one output word for the first LUT layer.
module logicnet_input_quantizer
    import logicnet_pkg::*;
#(
    parameter int NUM_FEATURES = 8,
    parameter int IN_WIDTH     = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            s_valid,
    output logic                            s_ready,
    input  logic [IN_WIDTH-1:0]             s_data,
    input  logic                            s_last,
    input  logic                            cfg_we,
    input  logic [$clog2(NUM_FEATURES)-1:0] cfg_feat,
    input  logic [1:0]                      cfg_sel,
    input  logic [IN_WIDTH-1:0]             cfg_data,
    output logic                            m_valid,
    input  logic                            m_ready,
    output logic [QBITS*NUM_FEATURES-1:0]   m_data,
    output logic                            frame_err
);

    localparam int FEAT_W = $clog2(NUM_FEATURES);
    localparam int VEC_W  = QBITS * NUM_FEATURES;

    logic [IN_WIDTH-1:0] thr [NUM_FEATURES][NUM_THR];
    logic [FEAT_W-1:0]   feat_cnt;
    logic [VEC_W-1:0]    asm_buf;
    logic [VEC_W-1:0]    asm_fill;
    logic [VEC_W-1:0]    out_src;
    logic [VEC_W-1:0]    out_data;
    logic                out_valid;
    asm_state_t          asm_state;
    asm_state_t          asm_next;

    logic [QBITS-1:0] code;
    logic             accept;
    logic             is_last_feat;
    logic             complete;
    logic             malformed;
    logic             drain;
    logic             out_free;
    logic             load_out;

    assign s_ready      = (asm_state == COLLECT) && !rst;
    assign accept       = s_valid && s_ready;
    assign is_last_feat = (feat_cnt == FEAT_W'(NUM_FEATURES - 1));
    assign complete     = accept && s_last && is_last_feat;
    assign malformed    = accept && (s_last != is_last_feat);
    assign drain        = out_valid && m_ready;
    assign out_free     = !out_valid || drain;
    assign m_valid      = out_valid;
    assign m_data       = out_data;

    logicnet_feature_quant #(
        .IN_WIDTH(IN_WIDTH)
    ) u_quant (
        .x   (s_data),
        .t0  (thr[feat_cnt][0]),
        .t1  (thr[feat_cnt][1]),
        .t2  (thr[feat_cnt][2]),
        .code(code)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int f = 0; f < NUM_FEATURES; f++) begin
                for (int j = 0; j < NUM_THR; j++) begin
                    thr[f][j] <= IN_WIDTH'(THR_DEFAULT[j]);
                end
            end
        end else if (cfg_we && cfg_sel != 2'd3 && int'(cfg_feat) < NUM_FEATURES) begin
            thr[cfg_feat][cfg_sel] <= cfg_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            asm_state <= COLLECT;
        end else begin
            asm_state <= asm_next;
        end
    end

    // A held (FULL) frame is already complete in asm_buf; otherwise the frame
    // being finished this cycle includes the code for the final beat.
    always_comb begin
        asm_next = asm_state;
        load_out = 1'b0;
        asm_fill = asm_buf;
        asm_fill[int'(feat_cnt)*QBITS +: QBITS] = code;
        case (asm_state)
            COLLECT: begin
                if (complete) begin
                    if (out_free) begin
                        load_out = 1'b1;
                    end else begin
                        asm_next = FULL;
                    end
                end
            end
            FULL: begin
                if (drain) begin
                    load_out = 1'b1;
                    asm_next = COLLECT;
                end
            end
            default: asm_next = COLLECT;
        endcase
        out_src = (asm_state == FULL) ? asm_buf : asm_fill;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            feat_cnt  <= '0;
            asm_buf   <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= malformed;
            if (accept) begin
                if (complete || malformed) begin
                    feat_cnt <= '0;
                end else begin
                    feat_cnt <= feat_cnt + FEAT_W'(1);
                end
                asm_buf <= malformed ? '0 : asm_fill;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (load_out) begin
            out_valid <= 1'b1;
            out_data  <= out_src;
        end else if (drain) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_logicnet_input_quantizer.sv
// Directed self-checking bench for logicnet_input_quantizer with default
// NUM_FEATURES=8, IN_WIDTH=16.
module tb_logicnet_input_quantizer;

    localparam int NF = 8;
    localparam int W  = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [W-1:0]  s_data = '0;
    logic          s_last = 1'b0;
    logic          cfg_we = 1'b0;
    logic [2:0]    cfg_feat = '0;
    logic [1:0]    cfg_sel = '0;
    logic [W-1:0]  cfg_data = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [2*NF-1:0] m_data;
    logic          frame_err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Hand-computed with default thresholds {-8192, 0, 8192}: codes {2,0,3,1,3,1,0,3}.
    int basic_samples [NF] = '{0, -9000, 9000, -1, 8192, -8192, -8193, 32767};
    int zero_samples  [NF] = '{0, 0, 0, 0, 0, 0, 0, 0};
    int high_samples  [NF] = '{9000, 9000, 9000, 9000, 9000, 9000, 9000, 9000};
    int cfg_samples   [NF] = '{0, 0, 50, 0, 0, 0, 0, 0};
    localparam logic [15:0] BASIC_PACKED = 16'hC772;
    localparam logic [15:0] ZERO_PACKED  = 16'hAAAA;
    localparam logic [15:0] HIGH_PACKED  = 16'hFFFF;
    localparam logic [15:0] CFG_PACKED   = 16'hAA9A;

    logicnet_input_quantizer #(
        .NUM_FEATURES(NF),
        .IN_WIDTH(W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_data(s_data),
        .s_last(s_last),
        .cfg_we(cfg_we),
        .cfg_feat(cfg_feat),
        .cfg_sel(cfg_sel),
        .cfg_data(cfg_data),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_data(m_data),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // Presents one beat and returns #1 after the edge that accepted it.
    task automatic applyStimulus(input int sample, input logic last);
        int budget;
        budget  = 0;
        s_valid = 1'b1;
        s_data  = W'(sample);
        s_last  = last;
        while (!s_ready && budget < 50) begin
            tick();
            budget++;
        end
        if (!s_ready) begin
            checks++;
            failures++;
            $display("[TB] FAIL beat_accept: s_ready=%0b want 1 within 50 cycles", s_ready);
        end
        tick();
    endtask

    task automatic sendFrame(input int samples [NF]);
        for (int i = 0; i < NF; i++) begin
            applyStimulus(samples[i], i == NF - 1);
        end
        idle();
    endtask

    task automatic cfgWrite(input int feat, input int sel, input int value);
        cfg_we   = 1'b1;
        cfg_feat = 3'(feat);
        cfg_sel  = 2'(sel);
        cfg_data = W'(value);
        tick();
        cfg_we   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        checks++; if (s_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_sready: got %0b want 0", s_ready); end
        checks++; if (m_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_mvalid: got %0b want 0", m_valid); end
        checks++; if (m_data !== 16'h0000) begin failures++; $display("[TB] FAIL reset_mdata: got %h want 0000", m_data); end
        checks++; if (frame_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_frame_err: got %0b want 0", frame_err); end
        rst = 1'b0;
        tick();
        checks++; if (s_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_release_sready: got %0b want 1", s_ready); end
    endtask

    task automatic test_basic();
        m_ready = 1'b1;
        for (int i = 0; i < NF; i++) begin
            applyStimulus(basic_samples[i], i == NF - 1);
            if (i == NF - 2) begin
                checks++; if (m_valid !== 1'b0) begin failures++; $display("[TB] FAIL basic_early_mvalid: got %0b want 0", m_valid); end
            end
        end
        idle();
        checks++; if (m_valid !== 1'b1) begin failures++; $display("[TB] FAIL basic_mvalid: got %0b want 1", m_valid); end
        checks++; if (m_data !== BASIC_PACKED) begin failures++; $display("[TB] FAIL basic_mdata: got %h want %h", m_data, BASIC_PACKED); end
        checks++; if (frame_err !== 1'b0) begin failures++; $display("[TB] FAIL basic_frame_err: got %0b want 0", frame_err); end
        tick();
        checks++; if (m_valid !== 1'b0) begin failures++; $display("[TB] FAIL basic_drained: got %0b want 0", m_valid); end
    endtask

    task automatic test_backpressure();
        m_ready = 1'b0;
        sendFrame(zero_samples);
        checks++; if (m_valid !== 1'b1) begin failures++; $display("[TB] FAIL bp_first_mvalid: got %0b want 1", m_valid); end
        checks++; if (m_data !== ZERO_PACKED) begin failures++; $display("[TB] FAIL bp_first_mdata: got %h want %h", m_data, ZERO_PACKED); end
        checks++; if (s_ready !== 1'b1) begin failures++; $display("[TB] FAIL bp_first_sready: got %0b want 1", s_ready); end
        sendFrame(high_samples);
        checks++; if (s_ready !== 1'b0) begin failures++; $display("[TB] FAIL bp_full_sready: got %0b want 0", s_ready); end
        checks++; if (m_data !== ZERO_PACKED) begin failures++; $display("[TB] FAIL bp_hold_mdata: got %h want %h", m_data, ZERO_PACKED); end
        repeat (3) tick();
        checks++; if (m_valid !== 1'b1) begin failures++; $display("[TB] FAIL bp_stable_mvalid: got %0b want 1", m_valid); end
        checks++; if (m_data !== ZERO_PACKED) begin failures++; $display("[TB] FAIL bp_stable_mdata: got %h want %h", m_data, ZERO_PACKED); end
        checks++; if (s_ready !== 1'b0) begin failures++; $display("[TB] FAIL bp_stable_sready: got %0b want 0", s_ready); end
        m_ready = 1'b1;
        tick();
        checks++; if (m_valid !== 1'b1) begin failures++; $display("[TB] FAIL bp_second_mvalid: got %0b want 1", m_valid); end
        checks++; if (m_data !== HIGH_PACKED) begin failures++; $display("[TB] FAIL bp_second_mdata: got %h want %h", m_data, HIGH_PACKED); end
        checks++; if (s_ready !== 1'b1) begin failures++; $display("[TB] FAIL bp_release_sready: got %0b want 1", s_ready); end
        tick();
        checks++; if (m_valid !== 1'b0) begin failures++; $display("[TB] FAIL bp_drained: got %0b want 0", m_valid); end
    endtask

    task automatic test_frame_err();
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(basic_samples[i], i == 3);
        end
        idle();
        checks++; if (frame_err !== 1'b1) begin failures++; $display("[TB] FAIL err_pulse: got %0b want 1", frame_err); end
        checks++; if (m_valid !== 1'b0) begin failures++; $display("[TB] FAIL err_no_output: got %0b want 0", m_valid); end
        tick();
        checks++; if (frame_err !== 1'b0) begin failures++; $display("[TB] FAIL err_single_pulse: got %0b want 0", frame_err); end
        sendFrame(basic_samples);
        checks++; if (m_valid !== 1'b1) begin failures++; $display("[TB] FAIL err_recover_mvalid: got %0b want 1", m_valid); end
        checks++; if (m_data !== BASIC_PACKED) begin failures++; $display("[TB] FAIL err_recover_mdata: got %h want %h", m_data, BASIC_PACKED); end
        checks++; if (frame_err !== 1'b0) begin failures++; $display("[TB] FAIL err_recover_frame_err: got %0b want 0", frame_err); end
        tick();
    endtask

    task automatic test_cfg();
        m_ready = 1'b1;
        // Mid-frame write of feature 2 T1 before feature 2 arrives.
        applyStimulus(cfg_samples[0], 1'b0);
        applyStimulus(cfg_samples[1], 1'b0);
        idle();
        cfgWrite(2, 1, 100);
        for (int i = 2; i < NF; i++) begin
            applyStimulus(cfg_samples[i], i == NF - 1);
        end
        idle();
        checks++; if (m_valid !== 1'b1) begin failures++; $display("[TB] FAIL cfg_mid_mvalid: got %0b want 1", m_valid); end
        checks++; if (m_data !== CFG_PACKED) begin failures++; $display("[TB] FAIL cfg_mid_mdata: got %h want %h", m_data, CFG_PACKED); end
        tick();
        cfgWrite(2, 1, 0);
        // The beat sharing its edge with the write must see the old T1=0.
        for (int i = 0; i < NF; i++) begin
            if (i == 2) begin
                cfg_we = 1'b1; cfg_feat = 3'd2; cfg_sel = 2'd1; cfg_data = W'(100);
            end
            applyStimulus(cfg_samples[i], i == NF - 1);
            cfg_we = 1'b0;
        end
        idle();
        checks++; if (m_data !== ZERO_PACKED) begin failures++; $display("[TB] FAIL cfg_same_cycle_mdata: got %h want %h", m_data, ZERO_PACKED); end
        tick();
        cfgWrite(0, 3, 32767);
        sendFrame(cfg_samples);
        checks++; if (m_data !== CFG_PACKED) begin failures++; $display("[TB] FAIL cfg_after_write_mdata: got %h want %h", m_data, CFG_PACKED); end
        tick();
        cfgWrite(2, 1, 0);
    endtask

    task automatic test_reset_midframe();
        m_ready = 1'b0;
        sendFrame(basic_samples);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 1'b0);
        end
        idle();
        rst = 1'b1;
        tick();
        checks++; if (m_valid !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_mvalid: got %0b want 0", m_valid); end
        checks++; if (m_data !== 16'h0000) begin failures++; $display("[TB] FAIL rstmid_mdata: got %h want 0000", m_data); end
        checks++; if (frame_err !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_frame_err: got %0b want 0", frame_err); end
        checks++; if (s_ready !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_sready: got %0b want 0", s_ready); end
        rst = 1'b0;
        tick();
        checks++; if (s_ready !== 1'b1) begin failures++; $display("[TB] FAIL rstmid_release_sready: got %0b want 1", s_ready); end
        checks++; if (frame_err !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_release_frame_err: got %0b want 0", frame_err); end
        m_ready = 1'b1;
        sendFrame(basic_samples);
        checks++; if (m_valid !== 1'b1) begin failures++; $display("[TB] FAIL rstmid_fresh_mvalid: got %0b want 1", m_valid); end
        checks++; if (m_data !== BASIC_PACKED) begin failures++; $display("[TB] FAIL rstmid_fresh_mdata: got %h want %h", m_data, BASIC_PACKED); end
        checks++; if (frame_err !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_fresh_frame_err: got %0b want 0", frame_err); end
        tick();
    endtask

    task automatic test_back_to_back();
        int pulses;
        int last_pulse;
        pulses     = 0;
        last_pulse = -1;
        m_ready    = 1'b1;
        for (int b = 0; b < 4 * NF; b++) begin
            applyStimulus(basic_samples[b % NF], (b % NF) == NF - 1);
            checks++; if (m_valid !== ((b % NF) == NF - 1)) begin failures++; $display("[TB] FAIL b2b_mvalid beat %0d: got %0b want %0b", b, m_valid, (b % NF) == NF - 1); end
            checks++; if (s_ready !== 1'b1) begin failures++; $display("[TB] FAIL b2b_sready beat %0d: got %0b want 1", b, s_ready); end
            if (m_valid === 1'b1) begin
                checks++; if (m_data !== BASIC_PACKED) begin failures++; $display("[TB] FAIL b2b_mdata beat %0d: got %h want %h", b, m_data, BASIC_PACKED); end
                if (last_pulse >= 0) begin
                    checks++; if (cyc - last_pulse != NF) begin failures++; $display("[TB] FAIL b2b_spacing: got %0d want %0d", cyc - last_pulse, NF); end
                end
                last_pulse = cyc;
                pulses++;
            end
        end
        idle();
        checks++; if (pulses != 4) begin failures++; $display("[TB] FAIL b2b_pulse_count: got %0d want 4", pulses); end
        tick();
        checks++; if (m_valid !== 1'b0) begin failures++; $display("[TB] FAIL b2b_drained: got %0b want 0", m_valid); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_frame_err();
        test_cfg();
        test_reset_midframe();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
